// File: rtl/fir_mac_sequencer.sv
// Drives one shared external MAC through an NTAPS-tap direct-form FIR, one tap per cycle.
// Owns the sample delay line, the coefficient table and the result handshake.
module fir_mac_sequencer #(
  parameter int unsigned NTAPS   = 8,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [19:0] s_data,
  input  logic        coef_we,
  input  logic [5:0]  coef_addr,
  input  logic [17:0] coef_data,
  input  logic [5:0]  cfg_shift,
  input  logic        cfg_round,
  input  logic        cfg_sat,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [37:0] m_data,
  output logic        busy,
  output logic [19:0] mac_a,
  output logic [17:0] mac_b,
  output logic        mac_load_acc,
  output logic [2:0]  mac_feedback,
  output logic [5:0]  mac_acc_fir,
  output logic [5:0]  mac_shift_right,
  output logic        mac_round,
  output logic        mac_saturate_enable,
  output logic        mac_subtract,
  output logic        mac_unsigned_a,
  output logic        mac_unsigned_b,
  input  logic [37:0] mac_z
);

  localparam int unsigned PW       = $clog2(NTAPS);
  localparam int unsigned LastTapI = NTAPS - 1;
  localparam logic [PW-1:0] LastTap  = LastTapI[PW-1:0];
  localparam logic [PW-1:0] NtapsMod = NTAPS[PW-1:0];
  localparam logic [2:0]    MacLat   = MAC_LAT[2:0];

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StOut
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] tap_q, tap_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [5:0]    cfg_shift_q;
  logic          cfg_round_q;
  logic          cfg_sat_q;
  logic [37:0]   m_data_q, m_data_d;

  logic [19:0]   delay_q [NTAPS];
  logic [17:0]   coef_q  [NTAPS];

  logic          accept;
  logic          coef_wr;
  logic [PW-1:0] rd_idx;

  assign accept  = (state_q == StIdle) && s_valid;
  assign coef_wr = (state_q == StIdle) && coef_we && (32'(coef_addr) < NTAPS);

  // (wr_ptr - tap) mod NTAPS; adding NTAPS on underflow also covers non power-of-two depths.
  always_comb begin
    rd_idx = wr_ptr_q - tap_q;
    if (wr_ptr_q < tap_q) begin
      rd_idx = wr_ptr_q - tap_q + NtapsMod;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    tap_d    = tap_q;
    cnt_d    = cnt_q;
    m_data_d = m_data_q;
    unique case (state_q)
      StIdle: begin
        if (s_valid) begin
          state_d = StRun;
          tap_d   = '0;
        end
      end
      StRun: begin
        if (tap_q == LastTap) begin
          state_d = StDrain;
          tap_d   = '0;
          cnt_d   = MacLat;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == 3'd1) begin
          state_d  = StOut;
          cnt_d    = '0;
          m_data_d = mac_z;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StOut: begin
        if (m_ready) begin
          state_d  = StIdle;
          wr_ptr_d = (wr_ptr_q == LastTap) ? '0 : wr_ptr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      tap_q       <= '0;
      cnt_q       <= '0;
      m_data_q    <= '0;
      cfg_shift_q <= '0;
      cfg_round_q <= 1'b0;
      cfg_sat_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      tap_q    <= tap_d;
      cnt_q    <= cnt_d;
      m_data_q <= m_data_d;
      if (accept) begin
        cfg_shift_q <= cfg_shift;
        cfg_round_q <= cfg_round;
        cfg_sat_q   <= cfg_sat;
      end
    end
  end

  // A same-cycle write and accept both land at this edge, so the sample sees the new coefficient.
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_q <= '{default: '0};
      coef_q  <= '{default: '0};
    end else begin
      if (accept) begin
        delay_q[wr_ptr_q] <= s_data;
      end
      if (coef_wr) begin
        coef_q[coef_addr[PW-1:0]] <= coef_data;
      end
    end
  end

  always_comb begin
    s_ready             = (state_q == StIdle);
    busy                = (state_q != StIdle);
    m_valid             = (state_q == StOut);
    m_data              = m_data_q;
    mac_a               = '0;
    mac_b               = '0;
    mac_load_acc        = 1'b0;
    mac_shift_right     = '0;
    mac_round           = 1'b0;
    mac_saturate_enable = 1'b0;
    mac_feedback        = '0;
    mac_acc_fir         = '0;
    mac_subtract        = 1'b0;
    mac_unsigned_a      = 1'b0;
    mac_unsigned_b      = 1'b0;
    if (state_q == StRun) begin
      mac_a        = delay_q[rd_idx];
      mac_b        = coef_q[tap_q];
      mac_load_acc = (tap_q == '0);
    end
    if ((state_q == StRun) || (state_q == StDrain)) begin
      mac_shift_right     = cfg_shift_q;
      mac_round           = cfg_round_q;
      mac_saturate_enable = cfg_sat_q;
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with a small two-stage signed MAC model behind it.
module tb_fir_mac_sequencer;

  localparam int unsigned NTAPS   = 8;
  localparam int unsigned MAC_LAT = 2;
  localparam logic signed [63:0] ZMax = (64'sd1 <<< 37) - 64'sd1;
  localparam logic signed [63:0] ZMin = -(64'sd1 <<< 37);

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid, s_ready;
  logic [19:0] s_data;
  logic        coef_we;
  logic [5:0]  coef_addr;
  logic [17:0] coef_data;
  logic [5:0]  cfg_shift;
  logic        cfg_round, cfg_sat;
  logic        m_valid, m_ready;
  logic [37:0] m_data;
  logic        busy;
  logic [19:0] mac_a;
  logic [17:0] mac_b;
  logic        mac_load_acc;
  logic [2:0]  mac_feedback;
  logic [5:0]  mac_acc_fir, mac_shift_right;
  logic        mac_round, mac_saturate_enable, mac_subtract, mac_unsigned_a, mac_unsigned_b;
  logic [37:0] mac_z;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(
    .NTAPS   (NTAPS),
    .MAC_LAT (MAC_LAT)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .s_valid             (s_valid),
    .s_ready             (s_ready),
    .s_data              (s_data),
    .coef_we             (coef_we),
    .coef_addr           (coef_addr),
    .coef_data           (coef_data),
    .cfg_shift           (cfg_shift),
    .cfg_round           (cfg_round),
    .cfg_sat             (cfg_sat),
    .m_valid             (m_valid),
    .m_ready             (m_ready),
    .m_data              (m_data),
    .busy                (busy),
    .mac_a               (mac_a),
    .mac_b               (mac_b),
    .mac_load_acc        (mac_load_acc),
    .mac_feedback        (mac_feedback),
    .mac_acc_fir         (mac_acc_fir),
    .mac_shift_right     (mac_shift_right),
    .mac_round           (mac_round),
    .mac_saturate_enable (mac_saturate_enable),
    .mac_subtract        (mac_subtract),
    .mac_unsigned_a      (mac_unsigned_a),
    .mac_unsigned_b      (mac_unsigned_b),
    .mac_z               (mac_z)
  );

  // MAC model: operand register stage, then accumulator; shift/round/saturate on the output.
  logic signed [19:0] ma_q;
  logic signed [17:0] mb_q;
  logic               ml_q;
  logic [5:0]         ms_q, ms2_q;
  logic               mr_q, mr2_q, mt_q, mt2_q;
  logic signed [63:0] acc_q, prod, zt;

  always_comb prod = 64'(ma_q) * 64'(mb_q);

  always @(posedge clk) begin
    if (reset) begin
      ma_q <= '0; mb_q <= '0; ml_q <= 1'b0; ms_q <= '0; mr_q <= 1'b0; mt_q <= 1'b0;
      acc_q <= '0; ms2_q <= '0; mr2_q <= 1'b0; mt2_q <= 1'b0;
    end else begin
      ma_q  <= mac_a;
      mb_q  <= mac_b;
      ml_q  <= mac_load_acc;
      ms_q  <= mac_shift_right;
      mr_q  <= mac_round;
      mt_q  <= mac_saturate_enable;
      acc_q <= ml_q ? prod : acc_q + prod;
      ms2_q <= ms_q;
      mr2_q <= mr_q;
      mt2_q <= mt_q;
    end
  end

  always_comb begin
    zt = acc_q;
    if (mr2_q && (ms2_q != 6'd0)) zt = zt + (64'sd1 <<< (ms2_q - 6'd1));
    zt = zt >>> ms2_q;
    if (mt2_q) begin
      if (zt > ZMax) zt = ZMax;
      else if (zt < ZMin) zt = ZMin;
    end
    mac_z = zt[37:0];
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; cfg_shift = '0; cfg_round = 1'b0; cfg_sat = 1'b0; m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic write_coef(input logic [5:0] addr, input logic [17:0] data);
    coef_we = 1'b1; coef_addr = addr; coef_data = data;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first RUN cycle.
  task automatic start_sample(input logic [19:0] d, input logic [5:0] sh, input logic rnd,
                              input logic sat);
    s_valid = 1'b1; s_data = d; cfg_shift = sh; cfg_round = rnd; cfg_sat = sat;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!m_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check_eq("m_valid_wait", 64'(m_valid), 64'd1);
  endtask

  task automatic release_out();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic run_sample(input logic [19:0] d, input logic [5:0] sh, input logic rnd,
                            input logic sat, output logic [37:0] res, output int lat);
    start_sample(d, sh, rnd, sat);
    wait_valid(lat);
    res = m_data;
    release_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [37:0] res;
    int          lat;

    do_reset();
    check_eq("rst_s_ready", 64'(s_ready), 64'd1);
    check_eq("rst_m_valid", 64'(m_valid), 64'd0);
    check_eq("rst_m_data", 64'(m_data), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_mac_a", 64'(mac_a), 64'd0);
    check_eq("rst_mac_b", 64'(mac_b), 64'd0);
    check_eq("rst_mac_load", 64'(mac_load_acc), 64'd0);

    // Impulse response: coef[k] = k+1.
    for (int k = 0; k < 8; k++) write_coef(6'(k), 18'(k + 1));
    start_sample(20'd1, 6'd0, 1'b0, 1'b0);
    check_eq("imp_tap0_load", 64'(mac_load_acc), 64'd1);
    check_eq("imp_tap0_a", 64'(mac_a), 64'd1);
    check_eq("imp_tap0_b", 64'(mac_b), 64'd1);
    check_eq("imp_s_ready_run", 64'(s_ready), 64'd0);
    check_eq("imp_tied_ctl", {mac_feedback, mac_acc_fir, mac_subtract, mac_unsigned_a,
                              mac_unsigned_b}, 64'd0);
    wait_valid(lat);
    check_eq("imp_lat0", 64'(lat), 64'd11);
    check_eq("imp_out0", 64'(m_data), 64'd1);
    release_out();
    for (int n = 1; n < 9; n++) begin
      run_sample(20'd0, 6'd0, 1'b0, 1'b0, res, lat);
      check_eq($sformatf("imp_out%0d", n), 64'(res), (n < 8) ? 64'(n + 1) : 64'd0);
      check_eq($sformatf("imp_lat%0d", n), 64'(lat), 64'd11);
    end

    // Signed extremes with saturation.
    do_reset();
    for (int k = 0; k < 8; k++) write_coef(6'(k), 18'h20000);
    start_sample(20'h80000, 6'd0, 1'b0, 1'b1);
    check_eq("ext_mac_a", 64'(mac_a), 64'h80000);
    check_eq("ext_mac_b", 64'(mac_b), 64'h20000);
    check_eq("ext_sat_en", 64'(mac_saturate_enable), 64'd1);
    wait_valid(lat);
    check_eq("ext_first", 64'(m_data), 64'h10_0000_0000);
    release_out();
    for (int n = 1; n < 8; n++) run_sample(20'h80000, 6'd0, 1'b0, 1'b1, res, lat);
    check_eq("ext_last", 64'(res), 64'h1F_FFFF_FFFF);

    // Backpressure in OUT.
    do_reset();
    write_coef(6'd0, 18'd7);
    start_sample(20'd3, 6'd0, 1'b0, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_m_data", 64'(m_data), 64'd21);
      check_eq("bp_m_valid", 64'(m_valid), 64'd1);
      check_eq("bp_s_ready", 64'(s_ready), 64'd0);
      check_eq("bp_busy", 64'(busy), 64'd1);
    end
    release_out();
    check_eq("bp_s_ready_after", 64'(s_ready), 64'd1);
    check_eq("bp_m_valid_after", 64'(m_valid), 64'd0);

    // Coefficient write during RUN is ignored.
    start_sample(20'd2, 6'd0, 1'b0, 1'b0);
    coef_we = 1'b1; coef_addr = 6'd0; coef_data = 18'd99;
    @(negedge clk);
    coef_we = 1'b0;
    wait_valid(lat);
    check_eq("cw_run_ignored", 64'(m_data), 64'd14);
    release_out();
    // Same write in IDLE alongside the accept is used by that sample.
    coef_we = 1'b1; coef_addr = 6'd0; coef_data = 18'd99;
    start_sample(20'd2, 6'd0, 1'b0, 1'b0);
    coef_we = 1'b0;
    wait_valid(lat);
    check_eq("cw_idle_used", 64'(m_data), 64'd198);
    release_out();

    // Reset in the middle of RUN.
    write_coef(6'd3, 18'h3FFFC);
    start_sample(20'd1, 6'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("mr_tap3_b", 64'(mac_b), 64'h3FFFC);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mr_busy", 64'(busy), 64'd0);
    check_eq("mr_s_ready", 64'(s_ready), 64'd1);
    check_eq("mr_m_valid", 64'(m_valid), 64'd0);
    check_eq("mr_m_data", 64'(m_data), 64'd0);
    check_eq("mr_mac_ab", {26'd0, mac_a, mac_b}, 64'd0);
    reset = 1'b0;
    write_coef(6'd0, 18'd5);
    for (int n = 0; n < 4; n++) begin
      run_sample((n == 0) ? 20'd1 : 20'd0, 6'd0, 1'b0, 1'b0, res, lat);
      check_eq($sformatf("mr_imp%0d", n), 64'(res), (n == 0) ? 64'd5 : 64'd0);
    end

    // Config latched at accept, later changes ignored.
    do_reset();
    write_coef(6'd0, 18'd1);
    start_sample(20'd16, 6'd4, 1'b1, 1'b0);
    cfg_shift = 6'd0; cfg_round = 1'b0;
    check_eq("cfg_run_shift", 64'(mac_shift_right), 64'd4);
    check_eq("cfg_run_round", 64'(mac_round), 64'd1);
    repeat (8) @(negedge clk);
    check_eq("cfg_drain_shift", 64'(mac_shift_right), 64'd4);
    check_eq("cfg_drain_a", 64'(mac_a), 64'd0);
    check_eq("cfg_drain_busy", 64'(busy), 64'd1);
    wait_valid(lat);
    check_eq("cfg_result", 64'(m_data), 64'd1);
    check_eq("cfg_out_shift", 64'(mac_shift_right), 64'd0);
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
